dual_core_dmem_arbiter: RTL and testbench
=========================================

Name: dual_core_dmem_arbiter

Overview:
- Shares one single-ported data memory between the MEM stages of core 0 and core 1 in the dual-core build.
- Arbitrates round-robin between the two cores, sequences each access (issue, fixed-latency read wait, completion), and returns read data and an ack to the granted core.
- Drives a per-core stall so each core's pipeline freezes while its load or store is pending.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Byte-enable width is DATA_W/8.
- MEM_LAT, 2, number of cycles from the mem_en cycle to the cycle in which mem_rdata is valid. Must be at least 1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- c0_req  in  1  core0 access request; level signal, held until c0_ack
- c0_we  in  1  1 = store, 0 = load
- c0_addr  in  ADDR_W  byte address
- c0_wdata  in  DATA_W  store data
- c0_be  in  DATA_W/8  byte enables
- c0_rdata  out  DATA_W  load data, valid from the c0_ack cycle until the next core0 load completes
- c0_ack  out  1  one-cycle completion pulse
- c0_stall  out  1  = c0_req & ~c0_ack (combinational)
- c1_req, c1_we, c1_addr, c1_wdata, c1_be, c1_rdata, c1_ack, c1_stall: same as core0
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  write strobe, qualified by mem_en
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched store data
- mem_be  out  DATA_W/8  latched byte enables
- mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after mem_en
- busy  out  1  state != IDLE
- last_grant  out  1  core ID of the most recently completed transaction

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant that core.
- IDLE, both requesting: grant the core not equal to last_grant.
- On grant: latch grant ID, we, addr, wdata and be into payload registers, then go to ISSUE.
- ISSUE:
  - mem_en = 1; mem_we = latched we.
  - Store: next state DONE.
  - Load: next state WAIT, with lat_cnt loaded to MEM_LAT-1.
- WAIT:
  - lat_cnt != 0: decrement lat_cnt and stay in WAIT.
  - lat_cnt == 0: capture mem_rdata into the granted core's rdata register, then go to DONE.
- DONE:
  - Pulse the granted core's ack for one cycle.
  - Set last_grant to the granted core ID.
  - Next state IDLE.
- Latency, request sampled in IDLE at cycle t0:
  - Store: mem_en at t0+1, ack at t0+2.
  - Load: mem_en at t0+1, ack at t0+2+MEM_LAT.
  - The IDLE cycle after DONE is a mandatory bubble. Minimum spacing between transactions is 3 cycles for stores and MEM_LAT+3 for loads.
- Requester protocol:
  - The core's pipeline advances on the ack edge, because stall is low in the ack cycle.
  - In the next cycle, req and payload belong to the next instruction.
  - Payload changes while stalled are ignored, since the payload is latched at grant.
- req dropped before ack: not legal. The transaction still completes, and mem_en and ack are still produced.
- Non-granted core: its stall stays high throughout and it has no effect on mem_*. It is served in the next IDLE cycle if still requesting, so the wait is bounded by one transaction.
- mem_en and mem_we are 0 outside ISSUE. mem_addr, mem_wdata and mem_be always reflect the payload registers.
- No alignment or range checks: address and byte enables pass through unchanged.
- Reset values:
  - state IDLE; payload registers 0; lat_cnt 0.
  - c0_rdata and c1_rdata are 0.
  - Acks 0; mem_en and mem_we 0; busy 0.
  - last_grant = 1, so core0 wins the first tie.
  - Stalls follow req (combinational).
- rst asserted in any state:
  - State is IDLE on the next edge.
  - No ack is issued and any outstanding load data is discarded.
  - A memory write already strobed is not undone.
- rdata registers update only on load completion for their own core. A store never alters rdata.

Test Plan:
- Core0 load, MEM_LAT=2, addr 0x100, memory returns 0xDEADBEEF at t0+3 -> mem_en=1, mem_we=0 at t0+1 only; c0_ack at t0+4; c0_rdata=0xDEADBEEF; c0_stall high t0..t0+3.
- Core1 store, addr 0x20, wdata 0x12345678, be 4'b0011 -> at t0+1: mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x12345678, mem_be=0011; c1_ack at t0+2; c1_rdata unchanged.
- After reset, both cores issue stores in the same cycle -> core0 acked at t0+2, core1 acked at t0+5. Repeat the simultaneous requests -> core0 is served first again, since last_grant=1 after core1 completes.
- Core0 requests continuously while core1 holds a load -> grants alternate 0,1,0,1; core1 is never skipped twice.
- rst pulsed during WAIT of a core0 load -> next cycle: busy=0, mem_en=0, no c0_ack, c0_rdata=0.
- Parameter sweep MEM_LAT=1 and MEM_LAT=4, single load -> ack at t0+3 and t0+6 respectively, with rdata sampled in the final WAIT cycle.

Source files
------------

// File: rtl/dual_core_dmem_arbiter.sv
// dual_core_dmem_arbiter: round-robin sharing of one single-ported data memory between two core MEM stages
module dual_core_dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c0_req,
  input  logic                c0_we,
  input  logic [ADDR_W-1:0]   c0_addr,
  input  logic [DATA_W-1:0]   c0_wdata,
  input  logic [DATA_W/8-1:0] c0_be,
  output logic [DATA_W-1:0]   c0_rdata,
  output logic                c0_ack,
  output logic                c0_stall,
  input  logic                c1_req,
  input  logic                c1_we,
  input  logic [ADDR_W-1:0]   c1_addr,
  input  logic [DATA_W-1:0]   c1_wdata,
  input  logic [DATA_W/8-1:0] c1_be,
  output logic [DATA_W-1:0]   c1_rdata,
  output logic                c1_ack,
  output logic                c1_stall,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                last_grant
);
  localparam int BE_W = DATA_W / 8;
  localparam int CNT_W = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t r_state, w_next;
  logic r_gnt, r_we, r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_c0_rdata, r_c1_rdata;
  logic [BE_W-1:0] r_be;
  logic [CNT_W-1:0] r_lat;
  logic w_any, w_gnt, w_take, w_cap;
  assign w_any = c0_req | c1_req;
  assign w_gnt = (c0_req & c1_req) ? ~r_last : c1_req;
  assign w_take = (r_state == IDLE) && w_any;
  assign w_cap = (r_state == WAIT) && (r_lat == '0);
  assign mem_addr = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_be = r_be;
  assign c0_rdata = r_c0_rdata;
  assign c1_rdata = r_c1_rdata;
  assign last_grant = r_last;
  assign c0_stall = c0_req & ~c0_ack;
  assign c1_stall = c1_req & ~c1_ack;
  // state register
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_next;
  end
  // next state: grant, issue, fixed-latency wait for loads, completion, bubble
  always_comb begin
    w_next = r_state == IDLE  ? (w_any ? ISSUE : IDLE) :
             r_state == ISSUE ? (r_we ? DONE : WAIT) :
             r_state == WAIT  ? (r_lat == '0 ? DONE : WAIT) : IDLE;
  end
  // state-decoded outputs: memory strobe in ISSUE, ack to the granted core in DONE
  always_comb begin
    mem_en = r_state == ISSUE;
    mem_we = mem_en & r_we;
    c0_ack = (r_state == DONE) & ~r_gnt;
    c1_ack = (r_state == DONE) & r_gnt;
    busy = r_state != IDLE;
  end
  // payload latch at grant, latency counter, per-core read data capture, round-robin history
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt <= 1'b0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_be <= '0;
      r_lat <= '0;
      r_c0_rdata <= '0;
      r_c1_rdata <= '0;
      r_last <= 1'b1;
    end else begin
      if (w_take) begin
        r_gnt <= w_gnt;
        r_we <= w_gnt ? c1_we : c0_we;
        r_addr <= w_gnt ? c1_addr : c0_addr;
        r_wdata <= w_gnt ? c1_wdata : c0_wdata;
        r_be <= w_gnt ? c1_be : c0_be;
      end
      if (r_state == ISSUE && !r_we) r_lat <= CNT_W'(MEM_LAT - 1);
      else if (r_state == WAIT && r_lat != '0) r_lat <= r_lat - 1'b1;
      if (w_cap && !r_gnt) r_c0_rdata <= mem_rdata;
      if (w_cap && r_gnt) r_c1_rdata <= mem_rdata;
      if (r_state == DONE) r_last <= r_gnt;
    end
  end
endmodule

// File: tb/tb_dual_core_dmem_arbiter.sv
// tb_dual_core_dmem_arbiter: scoreboard bench for the dual-core data memory arbiter
module tb_dual_core_dmem_arbiter;
  typedef struct {int cyc; bit core; logic [31:0] rd;} ack_t;
  typedef struct {int cyc; bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} mem_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_cmp = 0, n_bad = 0;
  ack_t ack_q[$];
  mem_t mem_q[$];
  logic c0_req, c0_we, c1_req, c1_we;
  logic [31:0] c0_addr, c0_wdata, c1_addr, c1_wdata, c0_rdata, c1_rdata;
  logic [3:0] c0_be, c1_be, mem_be;
  logic c0_ack, c0_stall, c1_ack, c1_stall, mem_en, mem_we, busy, last_grant;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rd0, rd1;
  logic [31:0] mem [256];
  dual_core_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_be(c0_be),
    .c0_rdata(c0_rdata), .c0_ack(c0_ack), .c0_stall(c0_stall),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_be(c1_be),
    .c1_rdata(c1_rdata), .c1_ack(c1_ack), .c1_stall(c1_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .busy(busy), .last_grant(last_grant));
  // memory model: byte-enabled writes, reads returned two cycles after mem_en
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 8'h40) ? 32'hDEADBEEF : 32'h0;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++) if (mem_be[b]) mem[mem_addr[9:2]][8*b+:8] <= mem_wdata[8*b+:8];
    end
    rd0 <= (mem_en && !mem_we) ? mem[mem_addr[9:2]] : 32'hBADBAD00;
    rd1 <= rd0;
  end
  assign mem_rdata = rd1;
  logic s1_req, s4_req, s1_ack, s4_ack, s1_men, s4_men;
  logic [31:0] s1_rd, s4_rd, s1_mrd, s4_mrd;
  logic s1_st0, s1_st1, s1_ack1, s1_mwe, s1_busy, s1_lg, s4_st0, s4_st1, s4_ack1, s4_mwe, s4_busy, s4_lg;
  logic [31:0] s1_rd1, s1_ma, s1_mwd, s4_rd1, s4_ma, s4_mwd;
  logic [3:0] s1_mbe, s4_mbe;
  int sw_t0 = -100;
  assign s1_mrd = (cyc == sw_t0 + 2) ? 32'h1111AAAA : 32'hBAD11111;
  assign s4_mrd = (cyc == sw_t0 + 5) ? 32'h4444BBBB : 32'hBAD44444;
  dual_core_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .c0_req(s1_req), .c0_we(1'b0), .c0_addr(32'h300), .c0_wdata(32'h0), .c0_be(4'hF),
    .c0_rdata(s1_rd), .c0_ack(s1_ack), .c0_stall(s1_st0),
    .c1_req(1'b0), .c1_we(1'b0), .c1_addr(32'h0), .c1_wdata(32'h0), .c1_be(4'h0),
    .c1_rdata(s1_rd1), .c1_ack(s1_ack1), .c1_stall(s1_st1),
    .mem_en(s1_men), .mem_we(s1_mwe), .mem_addr(s1_ma), .mem_wdata(s1_mwd), .mem_be(s1_mbe),
    .mem_rdata(s1_mrd), .busy(s1_busy), .last_grant(s1_lg));
  dual_core_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) u4 (
    .clk(clk), .rst(rst),
    .c0_req(s4_req), .c0_we(1'b0), .c0_addr(32'h300), .c0_wdata(32'h0), .c0_be(4'hF),
    .c0_rdata(s4_rd), .c0_ack(s4_ack), .c0_stall(s4_st0),
    .c1_req(1'b0), .c1_we(1'b0), .c1_addr(32'h0), .c1_wdata(32'h0), .c1_be(4'h0),
    .c1_rdata(s4_rd1), .c1_ack(s4_ack1), .c1_stall(s4_st1),
    .mem_en(s4_men), .mem_we(s4_mwe), .mem_addr(s4_ma), .mem_wdata(s4_mwd), .mem_be(s4_mbe),
    .mem_rdata(s4_mrd), .busy(s4_busy), .last_grant(s4_lg));
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", n, cyc, a, e);
    end
  endtask
  task automatic exp_ack(input bit c, input int t, input logic [31:0] rd);
    ack_q.push_back('{t, c, rd});
  endtask
  task automatic exp_mem(input int t, input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    mem_q.push_back('{t, we, a, wd, be});
  endtask
  task automatic pop_ack(input bit c, input logic [31:0] rd);
    ack_t e;
    if (ack_q.size() == 0) begin
      chk("ack_unexpected", {63'd0, c}, 64'hFFFF);
    end else begin
      e = ack_q.pop_front();
      chk("ack_core", {63'd0, c}, {63'd0, e.core});
      chk("ack_cycle", cyc, e.cyc);
      chk("ack_rdata", rd, e.rd);
    end
  endtask
  // monitor: every ack and every memory strobe is matched against the scoreboard
  always @(negedge clk) begin
    mem_t m;
    if (c0_ack) pop_ack(1'b0, c0_rdata);
    if (c1_ack) pop_ack(1'b1, c1_rdata);
    if (mem_en) begin
      if (mem_q.size() == 0) begin
        chk("mem_unexpected", mem_addr, 64'hFFFF_FFFF_FFFF);
      end else begin
        m = mem_q.pop_front();
        chk("mem_cycle", cyc, m.cyc);
        chk("mem_we", mem_we, m.we);
        chk("mem_addr", mem_addr, m.addr);
        chk("mem_wdata", mem_wdata, m.wdata);
        chk("mem_be", mem_be, m.be);
      end
    end
  end
  task automatic do_req(input bit c, input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    int n = 0;
    bit got;
    if (c) begin
      c1_req = 1; c1_we = we; c1_addr = a; c1_wdata = wd; c1_be = be;
    end else begin
      c0_req = 1; c0_we = we; c0_addr = a; c0_wdata = wd; c0_be = be;
    end
    do begin
      @(negedge clk);
      n++;
      got = c ? c1_ack : c0_ack;
    end while (!got && n < 60);
    chk(c ? "c1_ack_seen" : "c0_ack_seen", {63'd0, got}, 64'd1);
    @(posedge clk);
    #1;
    if (c) c1_req = 0; else c0_req = 0;
  endtask
  int t0, a1 = -1, a4 = -1, m1 = -1, m4 = -1;
  logic [31:0] r1, r4;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    c0_req = 0; c0_we = 0; c0_addr = 0; c0_wdata = 0; c0_be = 0;
    c1_req = 0; c1_we = 0; c1_addr = 0; c1_wdata = 0; c1_be = 0;
    s1_req = 0; s4_req = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_c0_ack", c0_ack, 0);
    chk("rst_c1_ack", c1_ack, 0);
    chk("rst_c0_rdata", c0_rdata, 0);
    chk("rst_c1_rdata", c1_rdata, 0);
    chk("rst_last_grant", last_grant, 1);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 0);
    // simultaneous stores twice: core0 first both times
    for (int r = 0; r < 2; r++) begin
      t0 = cyc;
      exp_mem(t0 + 1, 1, 32'h10 + 8 * r, 32'h11111111 + 32'h22222222 * r, 4'hF);
      exp_ack(0, t0 + 2, 32'h0);
      exp_mem(t0 + 4, 1, 32'h14 + 8 * r, 32'h22222222 + 32'h22222222 * r, 4'hF);
      exp_ack(1, t0 + 5, 32'h0);
      fork
        do_req(0, 1, 32'h10 + 8 * r, 32'h11111111 + 32'h22222222 * r, 4'hF);
        do_req(1, 1, 32'h14 + 8 * r, 32'h22222222 + 32'h22222222 * r, 4'hF);
      join
      chk("tie_last_grant", last_grant, 1);
    end
    // core0 load with stall profile
    t0 = cyc;
    exp_mem(t0 + 1, 0, 32'h100, 32'h0, 4'hF);
    exp_ack(0, t0 + 4, 32'hDEADBEEF);
    fork
      do_req(0, 0, 32'h100, 32'h0, 4'hF);
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("c0_stall_pending", c0_stall, 1);
        end
        @(negedge clk);
        chk("c0_stall_ack", c0_stall, 0);
      end
    join
    chk("load_last_grant", last_grant, 0);
    // core1 load, then core1 partial store leaves its rdata alone
    t0 = cyc;
    exp_mem(t0 + 1, 0, 32'h10, 32'h0, 4'hF);
    exp_ack(1, t0 + 4, 32'h11111111);
    do_req(1, 0, 32'h10, 32'h0, 4'hF);
    t0 = cyc;
    exp_mem(t0 + 1, 1, 32'h20, 32'h12345678, 4'b0011);
    exp_ack(1, t0 + 2, 32'h11111111);
    do_req(1, 1, 32'h20, 32'h12345678, 4'b0011);
    chk("store_c1_rdata", c1_rdata, 32'h11111111);
    // core0 streams stores while core1 holds loads: grants alternate 0,1,0,1,0
    t0 = cyc;
    exp_mem(t0 + 1, 1, 32'h40, 32'hA0A0A0A0, 4'hF);
    exp_ack(0, t0 + 2, 32'hDEADBEEF);
    exp_mem(t0 + 4, 0, 32'h100, 32'h0, 4'hF);
    exp_ack(1, t0 + 7, 32'hDEADBEEF);
    exp_mem(t0 + 9, 1, 32'h44, 32'hB1B1B1B1, 4'hF);
    exp_ack(0, t0 + 10, 32'hDEADBEEF);
    exp_mem(t0 + 12, 0, 32'h40, 32'h0, 4'hF);
    exp_ack(1, t0 + 15, 32'hA0A0A0A0);
    exp_mem(t0 + 17, 1, 32'h48, 32'hC2C2C2C2, 4'hF);
    exp_ack(0, t0 + 18, 32'hDEADBEEF);
    fork
      begin
        do_req(0, 1, 32'h40, 32'hA0A0A0A0, 4'hF);
        do_req(0, 1, 32'h44, 32'hB1B1B1B1, 4'hF);
        do_req(0, 1, 32'h48, 32'hC2C2C2C2, 4'hF);
      end
      begin
        do_req(1, 0, 32'h100, 32'h0, 4'hF);
        do_req(1, 0, 32'h40, 32'h0, 4'hF);
      end
    join
    // reset in the WAIT state of a core0 load
    t0 = cyc;
    exp_mem(t0 + 1, 0, 32'h44, 32'h0, 4'hF);
    c0_req = 1; c0_we = 0; c0_addr = 32'h44; c0_wdata = 0; c0_be = 4'hF;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    c0_req = 0;
    @(negedge clk);
    chk("wrst_busy", busy, 0);
    chk("wrst_mem_en", mem_en, 0);
    chk("wrst_c0_ack", c0_ack, 0);
    chk("wrst_c0_rdata", c0_rdata, 0);
    chk("wrst_last_grant", last_grant, 1);
    repeat (6) @(posedge clk);
    #1;
    // MEM_LAT sweep: 1 and 4
    sw_t0 = cyc;
    s1_req = 1;
    s4_req = 1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (s1_men && m1 < 0) m1 = cyc;
      if (s4_men && m4 < 0) m4 = cyc;
      if (s1_ack && a1 < 0) begin a1 = cyc; r1 = s1_rd; end
      if (s4_ack && a4 < 0) begin a4 = cyc; r4 = s4_rd; end
      @(posedge clk);
      #1;
      if (a1 >= 0) s1_req = 0;
      if (a4 >= 0) s4_req = 0;
    end
    chk("lat1_mem_en", m1, sw_t0 + 1);
    chk("lat1_ack", a1, sw_t0 + 3);
    chk("lat1_rdata", r1, 32'h1111AAAA);
    chk("lat4_mem_en", m4, sw_t0 + 1);
    chk("lat4_ack", a4, sw_t0 + 6);
    chk("lat4_rdata", r4, 32'h4444BBBB);
    chk("ack_q_drained", ack_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
